mips_fact_soc: RTL and testbench

- Minimal single-cycle MIPS32-subset system-on-chip: core, 32×32 register file, HI/LO, 16-word instruction ROM holding a fixed factorial program, 64-word data memory and a 4-register GPIO block.
- Reads n from gpI1 and writes n! to gpO2.
- Parks the PC at 0x34 when done; the 0x34 PC value is the completion flag used by the system bench.
- Top-level block of the factorial demonstrator.

---
 rtl/mips_fact_soc.sv | 175 +++++++++++++++++
 tb/tb_mips_fact_soc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mips_fact_soc.sv
// Single-cycle MIPS32-subset SoC running a fixed factorial program: n from gpI1, n! to gpO2, parks at 0x34.
// Define DBG_RF_PORT_EN to add the combinational debug register-file read port (ra3/rd3).
module mips_fact_soc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpI1,
  input  logic [31:0] gpI2,
  output logic [31:0] gpO1,
  output logic [31:0] gpO2,
  output logic [31:0] pc_current,
  output logic [31:0] instr
`ifdef DBG_RF_PORT_EN
  ,
  input  logic [4:0]  ra3,
  output logic [31:0] rd3
`endif
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  logic [31:0] pc_q, pc_d, pc_plus4, br_target;
  logic [31:0] rf_q [32];
  logic [31:0] hi_q, lo_q;
  logic [31:0] gpo1_q, gpo2_q;
  logic [31:0] dmem [64];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_se, rs_val, rt_val, addr, rd_data;
  logic [63:0] product;
  logic        rf_we, hilo_we, mem_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        dmem_sel, gpio_sel;
  logic        unused_addr_bits;

  // Instruction ROM: factorial program, unused words are nop
  always_comb begin
    instr = 32'h0000_0000;
    case (pc_q[5:2])
      4'd0:  instr = 32'h8C04_0900;  // lw    $a0,0x900($0)
      4'd1:  instr = 32'hAC04_0908;  // sw    $a0,0x908($0)
      4'd2:  instr = 32'h2002_0001;  // addi  $v0,$0,1
      4'd3:  instr = 32'h2009_0002;  // addi  $t1,$0,2
      4'd4:  instr = 32'h0089_402A;  // slt   $t0,$a0,$t1
      4'd5:  instr = 32'h1500_0004;  // bne   $t0,$0,0x28
      4'd6:  instr = 32'h0044_0019;  // multu $v0,$a0
      4'd7:  instr = 32'h0000_1012;  // mflo  $v0
      4'd8:  instr = 32'h2084_FFFF;  // addi  $a0,$a0,-1
      4'd9:  instr = 32'h0800_0004;  // j     0x10
      4'd10: instr = 32'hAC02_090C;  // sw    $v0,0x90C($0)
      4'd13: instr = 32'h0800_000D;  // j     0x34
      default: instr = 32'h0000_0000;
    endcase
  end

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm_se = {{16{instr[15]}}, instr[15:0]};

  assign rs_val    = rf_q[rs];
  assign rt_val    = rf_q[rt];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_se[29:0], 2'b00};
  assign addr      = rs_val + imm_se;
  assign product   = {32'd0, rs_val} * {32'd0, rt_val};

  assign dmem_sel = (addr[31:8] == 24'd0);
  assign gpio_sel = (addr[31:4] == 28'h000_0090);
  assign unused_addr_bits = &{1'b0, addr[1:0]};

  always_comb begin
    rd_data = 32'd0;
    if (dmem_sel) begin
      rd_data = dmem[addr[7:2]];
    end else if (gpio_sel) begin
      case (addr[3:2])
        2'd0: rd_data = gpI1;
        2'd1: rd_data = gpI2;
        2'd2: rd_data = gpo1_q;
        2'd3: rd_data = gpo2_q;
        default: rd_data = 32'd0;
      endcase
    end
  end

  // Decode/execute; anything not matched falls through as a nop
  always_comb begin
    pc_d    = pc_plus4;
    rf_we   = 1'b0;
    rf_wa   = rd;
    rf_wd   = 32'd0;
    hilo_we = 1'b0;
    mem_we  = 1'b0;
    case (op)
      OP_R: begin
        case (funct)
          F_ADD:   begin rf_we = 1'b1; rf_wd = rs_val + rt_val; end
          F_SUB:   begin rf_we = 1'b1; rf_wd = rs_val - rt_val; end
          F_AND:   begin rf_we = 1'b1; rf_wd = rs_val & rt_val; end
          F_OR:    begin rf_we = 1'b1; rf_wd = rs_val | rt_val; end
          F_SLT:   begin rf_we = 1'b1; rf_wd = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
          F_SLL:   begin rf_we = 1'b1; rf_wd = rt_val << shamt; end
          F_MFLO:  begin rf_we = 1'b1; rf_wd = lo_q; end
          F_MFHI:  begin rf_we = 1'b1; rf_wd = hi_q; end
          F_MULTU: hilo_we = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val + imm_se; end
      OP_SLTI: begin rf_we = 1'b1; rf_wa = rt; rf_wd = {31'd0, $signed(rs_val) < $signed(imm_se)}; end
      OP_LW:   begin rf_we = 1'b1; rf_wa = rt; rf_wd = rd_data; end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) pc_d = br_target;
      OP_BNE:  if (rs_val != rt_val) pc_d = br_target;
      OP_J:    pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      gpo1_q <= 32'd0;
      gpo2_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (rf_we && (rf_wa != 5'd0)) rf_q[rf_wa] <= rf_wd;
      if (hilo_we) begin
        hi_q <= product[63:32];
        lo_q <= product[31:0];
      end
      if (mem_we && gpio_sel && (addr[3:2] == 2'd2)) gpo1_q <= rt_val;
      if (mem_we && gpio_sel && (addr[3:2] == 2'd3)) gpo2_q <= rt_val;
    end
  end

  // Data memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we && dmem_sel) dmem[addr[7:2]] <= rt_val;
  end

  assign pc_current = pc_q;
  assign gpO1       = gpo1_q;
  assign gpO2       = gpo2_q;

`ifdef DBG_RF_PORT_EN
  assign rd3 = rf_q[ra3];
`endif

endmodule

// File: tb/tb_mips_fact_soc.sv
// Self-checking bench for mips_fact_soc: directed and randomized factorial runs against an arithmetic model.
module tb_mips_fact_soc;

  logic        clk;
  logic        rst;
  logic [31:0] gpI1, gpI2;
  logic [31:0] gpO1, gpO2, pc_current, instr;
`ifdef DBG_RF_PORT_EN
  logic [4:0]  ra3;
  logic [31:0] rd3;
`endif

  int checks = 0;
  int passed = 0;

  mips_fact_soc dut (
    .clk(clk), .rst(rst), .gpI1(gpI1), .gpI2(gpI2),
    .gpO1(gpO1), .gpO2(gpO2), .pc_current(pc_current), .instr(instr)
`ifdef DBG_RF_PORT_EN
    , .ra3(ra3), .rd3(rd3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fact_model(input logic [31:0] n);
    logic [31:0] r;
    r = 32'd1;
    if ($signed(n) < 2) return r;
    for (int unsigned k = 2; k <= n; k++) r = r * k;
    return r;
  endfunction

  function automatic int latency_model(input logic [31:0] n);
    if ($signed(n) < 2) return 9;
    return 9 + 6 * (int'(n) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reset, release, count edges until the park address; optionally alter gpI1 mid-run.
  task automatic run_case(input string tag, input logic [31:0] n,
                          input int glitch_edge, input logic [31:0] glitch_val);
    int  edges;
    bit  done;
    rst  = 1'b0;
    gpI1 = n;
    gpI2 = $urandom;
    @(negedge clk);
    rst = 1'b1;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == glitch_edge) gpI1 = glitch_val;
      if (pc_current == 32'h34) done = 1'b1;
    end
    check({tag, " latency"}, 32'(edges), 32'(latency_model(n)));
    check({tag, " gpO2"}, gpO2, fact_model(n));
    check({tag, " gpO1"}, gpO1, n);
  endtask

  initial begin
    int          parked;
    logic [31:0] n;

    rst  = 1'b0;
    gpI1 = 32'd7;
    gpI2 = 32'd0;
`ifdef DBG_RF_PORT_EN
    ra3 = 5'd0;
`endif
    repeat (2) @(negedge clk);
    check("reset pc", pc_current, 32'h0);
    check("reset gpO1", gpO1, 32'h0);
    check("reset gpO2", gpO2, 32'h0);
    check("reset instr", instr, 32'h8C04_0900);

    for (int i = 2; i <= 12; i++) run_case($sformatf("sweep n=%0d", i), 32'(i), -1, 32'd0);
    check("sweep 12 literal", gpO2, 32'd479001600);

    run_case("latency n=5", 32'd5, -1, 32'd0);
    check("n=5 literal", gpO2, 32'd120);
    parked = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pc_current == 32'h34) parked++;
    end
    check("park hold cycles", 32'(parked), 32'd20);

    run_case("edge n=0", 32'd0, -1, 32'd0);
    run_case("edge n=1", 32'd1, -1, 32'd0);
    run_case("edge n=-1", 32'hFFFF_FFFF, -1, 32'd0);
    run_case("edge n=13", 32'd13, -1, 32'd0);
    check("n=13 literal", gpO2, 32'd1932053504);

    // Mid-run reset: abort after 20 edges, restart with a new argument
    rst  = 1'b0;
    gpI1 = 32'd10;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async reset pc", pc_current, 32'h0);
    check("async reset gpO1", gpO1, 32'h0);
    run_case("restart n=4", 32'd4, -1, 32'd0);

    // gpI1 must only matter during the first lw
    for (int i = 0; i < 4; i++) begin
      n = 32'($urandom_range(2, 10));
      run_case($sformatf("sample-once n=%0d", n), n, 3 + i, $urandom);
    end

    for (int i = 0; i < 6; i++) begin
      n = 32'($urandom_range(0, 13));
      run_case($sformatf("rand n=%0d", n), n, -1, 32'd0);
    end
    n = $urandom | 32'h8000_0000;
    run_case($sformatf("rand neg n=0x%0h", n), n, -1, 32'd0);

`ifdef DBG_RF_PORT_EN
    run_case("dbg n=6", 32'd6, -1, 32'd0);
    ra3 = 5'd2;
    #1 check("dbg $v0", rd3, 32'd720);
    ra3 = 5'd4;
    #1 check("dbg $a0", rd3, 32'd1);
    ra3 = 5'd0;
    #1 check("dbg $0", rd3, 32'd0);
    ra3 = 5'd9;
    #1 check("dbg $t1", rd3, 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
